fetch_sequencer: RTL

- Instruction-fetch controller for the MIPS core. It owns the program counter and drives the address of the combinational instruction_mem (PC in, Instr out).
- Fetched {pc, instr} pairs go into a small FIFO. Decode drains the FIFO through a valid/ready handshake.
- Handles start, backpressure, branch/jump redirect with flush, and halt on a SYSCALL word.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package fetch_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_000C;
   localparam logic [31:0] PC_INC         = 32'd4;

   typedef logic [1:0] state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, fills the fetch FIFO, handles redirect/halt.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        busy,
   output logic        halted
);

   state_t       state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   fetch_entry_t din;
   fetch_entry_t head;

   assign imem_addr = pc_q;
   assign busy      = (state_q == ST_RUN);
   assign halted    = (state_q == ST_HALTED);
   assign out_valid = !empty;
   assign out_pc    = empty ? 32'h0 : head.pc;
   assign out_instr = empty ? 32'h0 : head.instr;
   assign pop       = out_valid && out_ready;
   assign push      = busy && !redirect_valid && (!full || pop);
   assign din       = '{pc: pc_q, instr: imem_instr};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & ~32'h3;
         if (state_q != ST_IDLE || start) begin
            state_d = ST_RUN;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (push) begin
                  pc_d = pc_q + PC_INC;
                  if (imem_instr == HALT_INSTR) state_d = ST_HALTED;
               end
            end
            ST_HALTED: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

endmodule
